// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, tracks the 1-cycle memory read and feeds decode through a skid buffer.
// Build option IFC_PERF_CNT_EN adds saturating issue/stall counters with a synchronous clear.
module instr_fetch_ctrl #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    MEM_DEPTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   branch_valid,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0]  id_pc,
  output logic                   halted,
  output logic                   range_err
`ifdef IFC_PERF_CNT_EN
  ,
  input  logic                   perf_clr,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   pc_r;
  logic                    inflight_r;
  logic [ADDR_WIDTH-1:0]   inflight_pc_r;
  logic                    skid_valid_r;
  logic [INSTR_WIDTH-1:0]  skid_instr_r;
  logic [ADDR_WIDTH-1:0]   skid_pc_r;
  logic                    pc_in_range_s;
  logic                    tgt_in_range_s;
  logic                    out_free_s;
  logic                    issue_en_s;

  assign imem_addr = pc_r;

  // Issue gating: never issue when a returning word would find both the output and the skid occupied.
  always_comb begin
    pc_in_range_s  = (pc_r < DEPTH_A);
    tgt_in_range_s = (branch_target < DEPTH_A);
    out_free_s     = ~id_valid | id_ready;
    issue_en_s     = (state_r == S_RUN) & ~skid_valid_r
                   & ~(id_valid & ~id_ready & inflight_r) & pc_in_range_s;
  end

  // Next-state selection; a branch overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (branch_valid) begin
      state_nxt_s = tgt_in_range_s ? S_RUN : S_DRAIN;
    end else begin
      case (state_r)
        S_IDLE, S_HALT: state_nxt_s = start ? S_RUN : state_r;
        S_RUN: begin
          if ((issue_en_s && (pc_r == LAST_PC)) || !pc_in_range_s) begin
            state_nxt_s = S_DRAIN;
          end else begin
            state_nxt_s = S_RUN;
          end
        end
        S_DRAIN: begin
          if (!inflight_r && !skid_valid_r && !id_valid) begin
            state_nxt_s = S_HALT;
          end else begin
            state_nxt_s = S_DRAIN;
          end
        end
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // FSM, PC, in-flight tracking, skid buffer and decode output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {ADDR_WIDTH{1'b0}};
      skid_valid_r  <= 1'b0;
      skid_instr_r  <= {INSTR_WIDTH{1'b0}};
      skid_pc_r     <= {ADDR_WIDTH{1'b0}};
      id_valid      <= 1'b0;
      id_instr      <= {INSTR_WIDTH{1'b0}};
      id_pc         <= {ADDR_WIDTH{1'b0}};
      halted        <= 1'b0;
      range_err     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      halted  <= (state_nxt_s == S_HALT);
      if (branch_valid) begin
        id_valid     <= 1'b0;
        skid_valid_r <= 1'b0;
        inflight_r   <= 1'b0;
        if (tgt_in_range_s) begin
          pc_r <= branch_target;
        end else begin
          range_err <= 1'b1;
        end
      end else begin
        inflight_r <= issue_en_s;
        if (issue_en_s) begin
          inflight_pc_r <= pc_r;
          pc_r          <= pc_r + ADDR_WIDTH'(1);
        end
        // The skid always holds the older word, so it drains first.
        if (out_free_s) begin
          if (skid_valid_r) begin
            id_valid     <= 1'b1;
            id_instr     <= skid_instr_r;
            id_pc        <= skid_pc_r;
            skid_valid_r <= inflight_r;
            skid_instr_r <= imem_rdata;
            skid_pc_r    <= inflight_pc_r;
          end else if (inflight_r) begin
            id_valid <= 1'b1;
            id_instr <= imem_rdata;
            id_pc    <= inflight_pc_r;
          end else begin
            id_valid <= 1'b0;
          end
        end else if (inflight_r) begin
          skid_valid_r <= 1'b1;
          skid_instr_r <= imem_rdata;
          skid_pc_r    <= inflight_pc_r;
        end
      end
    end
  end

`ifdef IFC_PERF_CNT_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Saturating issue and stall counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else if (perf_clr) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (issue_en_s && !branch_valid && (perf_fetched != CNT_MAX)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (id_valid && !id_ready && (perf_stall != CNT_MAX)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: queue-based reference model plus directed scenarios and random traffic.
module tb_instr_fetch_ctrl;
  localparam int DEPTH = 32;
  localparam int MI = 0, MR = 1, MD = 2, MH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        id_ready = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        halted;
  logic        range_err;
`ifdef IFC_PERF_CNT_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  logic [31:0] mem [DEPTH];
  int checks = 0;
  int errors = 0;

  // reference model: program counter, word arriving from memory, buffered words, decode slot
  int m_state, m_pc, m_arr, m_out_pc, m_issues;
  bit m_out_v, m_rerr;
  int m_buf[$];
  int xfer[$];
  int exp_q[$];

  instr_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .halted(halted), .range_err(range_err)
`ifdef IFC_PERF_CNT_EN
    , .perf_clr(perf_clr), .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= (imem_addr < 32'd32) ? mem[imem_addr[4:0]] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc, issue, empty_now;
    int cand[$];
    empty_now = (m_arr < 0) && (m_buf.size() == 0) && !m_out_v;
    acc = m_out_v && id_ready;
    if (branch_valid) begin
      m_out_v = 1'b0;
      m_buf.delete();
      m_arr = -1;
      if (branch_target < DEPTH) begin
        m_pc = int'(branch_target);
        m_state = MR;
      end else begin
        m_rerr = 1'b1;
        m_state = MD;
      end
    end else begin
      issue = (m_state == MR) && (m_buf.size() == 0)
            && !(m_out_v && !id_ready && m_arr >= 0) && (m_pc < DEPTH);
      cand = m_buf;
      if (m_arr >= 0) cand.push_back(m_arr);
      if (acc) m_out_v = 1'b0;
      if (!m_out_v && cand.size() > 0) begin
        m_out_v = 1'b1;
        m_out_pc = cand.pop_front();
      end
      m_buf = cand;
      case (m_state)
        MI, MH: if (start) m_state = MR;
        MR: if (m_pc >= DEPTH || (issue && m_pc == DEPTH - 1)) m_state = MD;
        MD: if (empty_now) m_state = MH;
        default: m_state = MI;
      endcase
      if (issue) begin
        m_arr = m_pc;
        m_pc++;
        m_issues++;
      end else begin
        m_arr = -1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_state = MI; m_pc = 0; m_arr = -1; m_out_v = 1'b0; m_out_pc = 0;
      m_rerr = 1'b0; m_issues = 0; m_buf.delete();
    end else begin
      model_step();
    end
  end

  // compare process: every cycle out of reset
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("id_valid", id_valid, m_out_v);
      if (m_out_v) begin
        chk("id_pc", id_pc, m_out_pc);
        chk("id_instr", id_instr, mem[m_out_pc]);
      end
      chk("halted", halted, m_state == MH);
      chk("range_err", range_err, m_rerr);
      chk("imem_addr", imem_addr, m_pc);
    end
  end

  // record DUT transfers (taken at the next rising edge)
  initial forever begin
    @(negedge clk);
    if (!rst_n) xfer.delete();
    else if (id_valid && id_ready) xfer.push_back(int'(id_pc));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; branch_valid = 1'b0; id_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_shown(input int pc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (id_valid && id_pc == pc) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_pc%0d timeout", pc);
    end
  endtask

  task automatic wait_halt();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (halted) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_halt timeout");
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(i);
  endtask

  task automatic cmp_xfer(input string name);
    int nbad;
    nbad = 0;
    chk({name, "_count"}, xfer.size(), exp_q.size());
    for (int i = 0; i < xfer.size() && i < exp_q.size(); i++)
      if (xfer[i] != exp_q[i]) nbad++;
    chk({name, "_order"}, nbad, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i + 100);
    #12;
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_imem_addr", imem_addr, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // straight-line program with latency and end-of-program halt
    pulse_start();
    step(); chk("lat_c1_valid", id_valid, 0);
    step(); chk("lat_c2_valid", id_valid, 1);
    chk("lat_c2_pc", id_pc, 0);
    chk("lat_c2_instr", id_instr, 100);
    wait_shown(31);
    step(); chk("drain_halted", halted, 0);
    step(); chk("end_halted", halted, 1);
    exp_q.delete(); push_range(0, 31); cmp_xfer("seq");

    // backpressure at word 4
    do_reset();
    pulse_start();
    wait_shown(4);
    id_ready = 1'b0;
    repeat (3) begin
      step();
      chk("stall_valid", id_valid, 1);
      chk("stall_instr", id_instr, 104);
    end
    id_ready = 1'b1;
    wait_halt();
    exp_q.delete(); push_range(0, 31); cmp_xfer("stall");
`ifdef IFC_PERF_CNT_EN
    chk("perf_stall", perf_stall, 3);
    chk("perf_fetched", perf_fetched, 32);
    chk("perf_fetched_model", perf_fetched, m_issues);
    perf_clr = 1'b1; step(); perf_clr = 1'b0;
    chk("perf_clr_fetched", perf_fetched, 0);
    chk("perf_clr_stall", perf_stall, 0);
`endif

    // branch to 20 while 6 pending and 7 in flight
    do_reset();
    pulse_start();
    wait_shown(6);
    branch_valid = 1'b1; branch_target = 32'd20; id_ready = 1'b0;
    step();
    branch_valid = 1'b0; id_ready = 1'b1;
    chk("br_flush_valid", id_valid, 0);
    step(); chk("br_c1_valid", id_valid, 0);
    step(); chk("br_c2_valid", id_valid, 1);
    chk("br_c2_pc", id_pc, 20);
    chk("br_c2_instr", id_instr, 120);
    wait_halt();
    exp_q.delete(); push_range(0, 5); push_range(20, 31); cmp_xfer("branch");

    // out-of-range branch with the pending word accepted the same cycle
    do_reset();
    pulse_start();
    wait_shown(3);
    branch_valid = 1'b1; branch_target = 32'd40;
    step();
    branch_valid = 1'b0;
    chk("oor_range_err", range_err, 1);
    chk("oor_valid", id_valid, 0);
    chk("oor_drain", halted, 0);
    step();
    chk("oor_halted", halted, 1);
    chk("oor_pc_kept", imem_addr, 5);
    pulse_start();
    step(); step();
    chk("oor_resume_valid", id_valid, 1);
    chk("oor_resume_pc", id_pc, 5);
    wait_halt();
    chk("oor_sticky", range_err, 1);
    exp_q.delete(); push_range(0, 3); push_range(5, 31); cmp_xfer("oor");

    // asynchronous reset with the skid full
    do_reset();
    pulse_start();
    wait_shown(10);
    id_ready = 1'b0;
    step(); step();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", id_valid, 0);
    chk("arst_pc", id_pc, 0);
    chk("arst_instr", id_instr, 0);
    chk("arst_halted", halted, 0);
    chk("arst_range_err", range_err, 0);
    chk("arst_imem_addr", imem_addr, 0);
    id_ready = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    pulse_start();
    step(); step();
    chk("arst_restart_valid", id_valid, 1);
    chk("arst_restart_pc", id_pc, 0);

    // random traffic against the model
    rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      id_ready      = ($urandom_range(0, 9) < 7);
      branch_valid  = ($urandom_range(0, 39) == 0);
      branch_target = 32'($urandom_range(0, 47));
      start         = ($urandom_range(0, 19) == 0);
      step();
    end
    start = 1'b0; branch_valid = 1'b0; id_ready = 1'b1;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
